// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline stage controller and the hazard
// detection unit.
//   - pipe_state_e : controller FSM state encoding
//   - req_e        : hazard request kinds; the numeric value is the priority,
//                    so a larger value always wins
//   - NOP_CTRL     : control-field encoding injected as a bubble
//   - pick_req()   : resolves simultaneous requests to the winning one
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_BUBBLE = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_FREEZE = 2'd3
    } pipe_state_e;

    // Encoded so that the numerically larger request has the higher priority
    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_LD   = 2'd1,
        REQ_BR   = 2'd2,
        REQ_FRZ  = 2'd3
    } req_e;

    localparam logic [1:0] PRIO_LD  = 2'd1;
    localparam logic [1:0] PRIO_BR  = 2'd2;
    localparam logic [1:0] PRIO_FRZ = 2'd3;

    // Control encoding placed into the stage that receives a bubble
    localparam logic [5:0] NOP_CTRL = 6'd63;

    // Returns the highest-priority active request: freeze > branch > load-use
    function automatic req_e pick_req(input logic ld, input logic br, input logic frz);
        req_e r;
        if (frz) begin
            r = REQ_FRZ;
        end else if (br) begin
            r = REQ_BR;
        end else if (ld) begin
            r = REQ_LD;
        end else begin
            r = REQ_NONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_ctrl_cnt.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_cnt
// Freeze down-counter plus saturating stall-cycle performance counter.
// All state changes on the falling clock edge.
// Ports:
//   Clk          : clock (falling-edge active)
//   Rst          : asynchronous active-high reset
//   load_i       : load the freeze counter with load_val_i
//   load_val_i   : freeze length to load (already adjusted so it is never 0)
//   dec_i        : decrement the freeze counter
//   stall_any_i  : current cycle has at least one stall bit set
//   frz_cnt_o    : freeze counter value
//   stall_cnt_o  : saturating count of stalled cycles
// -----------------------------------------------------------------------------
module pipe_ctrl_cnt #(
    parameter int CNT_W  = 4,
    parameter int PERF_W = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              load_i,
    input  logic [CNT_W-1:0]  load_val_i,
    input  logic              dec_i,
    input  logic              stall_any_i,
    output logic [CNT_W-1:0]  frz_cnt_o,
    output logic [PERF_W-1:0] stall_cnt_o
);

    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);
    localparam logic [PERF_W-1:0] PERF_ZERO = {PERF_W{1'b0}};
    localparam logic [PERF_W-1:0] PERF_ONE  = PERF_W'(1'b1);
    localparam logic [PERF_W-1:0] PERF_MAX  = {PERF_W{1'b1}};

    logic [CNT_W-1:0]  frz_cnt_q;
    logic [CNT_W-1:0]  frz_cnt_d;
    logic [PERF_W-1:0] perf_q;
    logic [PERF_W-1:0] perf_d;

    // Next value of the freeze counter: load wins over decrement, never underflows
    always_comb begin
        frz_cnt_d = frz_cnt_q;
        if (load_i) begin
            frz_cnt_d = load_val_i;
        end else if (dec_i && (frz_cnt_q != CNT_ZERO)) begin
            frz_cnt_d = frz_cnt_q - CNT_ONE;
        end else begin
            frz_cnt_d = frz_cnt_q;
        end
    end

    // Next value of the stall-cycle counter, holding at all-ones
    always_comb begin
        perf_d = perf_q;
        if (stall_any_i && (perf_q != PERF_MAX)) begin
            perf_d = perf_q + PERF_ONE;
        end else begin
            perf_d = perf_q;
        end
    end

    // Counter registers, cleared asynchronously by reset
    always_ff @(negedge Clk or posedge Rst) begin
        if (Rst) begin
            frz_cnt_q <= CNT_ZERO;
            perf_q    <= PERF_ZERO;
        end else begin
            frz_cnt_q <= frz_cnt_d;
            perf_q    <= perf_d;
        end
    end

    assign frz_cnt_o   = frz_cnt_q;
    assign stall_cnt_o = perf_q;

endmodule

// File: rtl/pipe_stage_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stage_ctrl
// Pipeline stage controller: turns load-use, branch and freeze requests into
// per-stage stall / flush controls and a bubble (nop) indication.
// State changes on the falling edge of Clk so the Moore outputs are stable
// through the following high phase, when the stage registers sample them.
// Ports:
//   Clk         : clock (falling-edge active)
//   Rst         : asynchronous active-high reset
//   ld_use_req  : load-use hazard -> stall lower stages, bubble at BUBBLE_AT
//   br_req      : taken branch/jump -> flush stages 1..FLUSH_DEPTH
//   frz_req     : multi-cycle freeze request
//   frz_len     : freeze length in cycles (0 behaves as 1)
//   stall       : per-stage hold (bit 0 = PC ... bit 4 = MEM_WB)
//   flush       : per-stage clear
//   nop         : controls entering stage BUBBLE_AT are forced to NOP_CTRL
//   busy        : controller is not in NORMAL
//   stall_cnt   : saturating count of cycles with any stall bit set
// -----------------------------------------------------------------------------
module pipe_stage_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_STAGES  = 5,
    parameter int BUBBLE_AT   = 2,
    parameter int FLUSH_DEPTH = 1,
    parameter int CNT_W       = 4,
    parameter int PERF_W      = 16
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  ld_use_req,
    input  logic                  br_req,
    input  logic                  frz_req,
    input  logic [CNT_W-1:0]      frz_len,
    output logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] flush,
    output logic                  nop,
    output logic                  busy,
    output logic [PERF_W-1:0]     stall_cnt
);

    // Elaboration-time parameter sanity checks
    if (BUBBLE_AT > NUM_STAGES - 1) begin : g_bad_bubble_at
        $error("pipe_stage_ctrl: BUBBLE_AT must be <= NUM_STAGES-1");
    end
    if (FLUSH_DEPTH > NUM_STAGES - 1) begin : g_bad_flush_depth
        $error("pipe_stage_ctrl: FLUSH_DEPTH must be <= NUM_STAGES-1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pipe_stage_ctrl: CNT_W must be >= 1");
    end

    localparam logic [CNT_W-1:0]      CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1'b1);
    localparam logic [NUM_STAGES-1:0] STAGE_NONE = {NUM_STAGES{1'b0}};
    localparam logic [NUM_STAGES-1:0] STAGE_ALL  = {NUM_STAGES{1'b1}};

    pipe_state_e state_q;
    pipe_state_e state_d;
    logic        pend_q;
    logic        pend_d;

    logic [NUM_STAGES-1:0] stall_q;
    logic [NUM_STAGES-1:0] stall_d;
    logic [NUM_STAGES-1:0] flush_q;
    logic [NUM_STAGES-1:0] flush_d;
    logic                  nop_q;
    logic                  nop_d;
    logic                  busy_q;
    logic                  busy_d;

    logic [NUM_STAGES-1:0] bubble_mask_s;
    logic [NUM_STAGES-1:0] flush_mask_s;
    logic [CNT_W-1:0]      frz_cnt_s;
    logic [CNT_W-1:0]      frz_load_val_s;
    logic                  cnt_load_s;
    logic                  cnt_dec_s;
    req_e                  win_s;

    // Constant stage masks: stages below the bubble point hold; 1..FLUSH_DEPTH clear
    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_mask
        assign bubble_mask_s[i] = (i < BUBBLE_AT);
        assign flush_mask_s[i]  = (i >= 1) && (i <= FLUSH_DEPTH);
    end

    // A zero freeze length still freezes for one cycle
    assign frz_load_val_s = (frz_len == CNT_ZERO) ? CNT_ONE : frz_len;
    assign win_s          = pick_req(ld_use_req, br_req, frz_req);

    // Next-state logic, pending-flush bookkeeping and freeze counter control
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        cnt_load_s = 1'b0;
        cnt_dec_s  = 1'b0;
        case (state_q)
            ST_FREEZE: begin
                if (frz_cnt_s == CNT_ONE) begin
                    if (frz_req) begin
                        // Request on the final cycle extends the freeze
                        state_d    = ST_FREEZE;
                        cnt_load_s = 1'b1;
                        pend_d     = pend_q | br_req;
                    end else if (pend_q || br_req) begin
                        state_d = ST_FLUSH;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = ST_NORMAL;
                        pend_d  = 1'b0;
                    end
                end else begin
                    // Earlier freeze cycles: only a branch is remembered
                    state_d   = ST_FREEZE;
                    cnt_dec_s = 1'b1;
                    pend_d    = pend_q | br_req;
                end
            end
            default: begin
                // NORMAL, BUBBLE and FLUSH all decide like NORMAL, except a
                // load-use request is dropped while busy (it is re-raised).
                case (win_s)
                    REQ_FRZ: begin
                        state_d    = ST_FREEZE;
                        cnt_load_s = 1'b1;
                        pend_d     = br_req;
                    end
                    REQ_BR: begin
                        state_d = ST_FLUSH;
                        pend_d  = 1'b0;
                    end
                    REQ_LD: begin
                        if (state_q == ST_NORMAL) begin
                            state_d = ST_BUBBLE;
                        end else begin
                            state_d = ST_NORMAL;
                        end
                        pend_d = 1'b0;
                    end
                    default: begin
                        state_d = ST_NORMAL;
                        pend_d  = 1'b0;
                    end
                endcase
            end
        endcase
    end

    // Moore output decode from the next state, registered alongside the state
    always_comb begin
        stall_d = STAGE_NONE;
        flush_d = STAGE_NONE;
        nop_d   = 1'b0;
        case (state_d)
            ST_NORMAL: begin
                stall_d = STAGE_NONE;
                flush_d = STAGE_NONE;
                nop_d   = 1'b0;
            end
            ST_BUBBLE: begin
                stall_d = bubble_mask_s;
                nop_d   = 1'b1;
            end
            ST_FLUSH: begin
                flush_d = flush_mask_s;
            end
            ST_FREEZE: begin
                stall_d = STAGE_ALL;
            end
            default: begin
                stall_d = STAGE_NONE;
                flush_d = STAGE_NONE;
                nop_d   = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_NORMAL);
    end

    // State, pending flag and output registers; reset drops everything at once
    always_ff @(negedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_NORMAL;
            pend_q  <= 1'b0;
            stall_q <= STAGE_NONE;
            flush_q <= STAGE_NONE;
            nop_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
            nop_q   <= nop_d;
            busy_q  <= busy_d;
        end
    end

    pipe_ctrl_cnt #(
        .CNT_W  (CNT_W),
        .PERF_W (PERF_W)
    ) u_cnt (
        .Clk         (Clk),
        .Rst         (Rst),
        .load_i      (cnt_load_s),
        .load_val_i  (frz_load_val_s),
        .dec_i       (cnt_dec_s),
        .stall_any_i (|stall_q),
        .frz_cnt_o   (frz_cnt_s),
        .stall_cnt_o (stall_cnt)
    );

    assign stall = stall_q;
    assign flush = flush_q;
    assign nop   = nop_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_ctrl
// Directed bench for pipe_stage_ctrl (FLUSH_DEPTH = 2, PERF_W = 4). Each step
// pushes the expected controls for the state entered at the next falling edge,
// then pops and compares them in the following high phase.
// -----------------------------------------------------------------------------
module tb_pipe_stage_ctrl;

    localparam logic [4:0] Z     = 5'b00000;
    localparam logic [4:0] S_BUB = 5'b00011;
    localparam logic [4:0] S_ALL = 5'b11111;
    localparam logic [4:0] F_BR  = 5'b00110;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       ld_use_req;
    logic       br_req;
    logic       frz_req;
    logic [3:0] frz_len;
    logic [4:0] stall;
    logic [4:0] flush;
    logic       nop;
    logic       busy;
    logic [3:0] stall_cnt;

    typedef struct {
        string      tag;
        logic [4:0] stall;
        logic [4:0] flush;
        logic       nop;
        logic       busy;
    } exp_t;

    exp_t sb[$];
    int   errors  = 0;
    int   checks  = 0;
    int   exp_cnt = 0;

    pipe_stage_ctrl #(
        .NUM_STAGES  (5),
        .BUBBLE_AT   (2),
        .FLUSH_DEPTH (2),
        .CNT_W       (4),
        .PERF_W      (4)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .ld_use_req (ld_use_req),
        .br_req     (br_req),
        .frz_req    (frz_req),
        .frz_len    (frz_len),
        .stall      (stall),
        .flush      (flush),
        .nop        (nop),
        .busy       (busy),
        .stall_cnt  (stall_cnt)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Pop the oldest expectation and compare it with the current outputs
    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".stall"}, {27'd0, stall}, {27'd0, e.stall});
            chk({e.tag, ".flush"}, {27'd0, flush}, {27'd0, e.flush});
            chk({e.tag, ".nop"},   {31'd0, nop},   {31'd0, e.nop});
            chk({e.tag, ".busy"},  {31'd0, busy},  {31'd0, e.busy});
            chk({e.tag, ".cnt"},   {28'd0, stall_cnt}, exp_cnt);
            if (e.stall != Z) begin
                exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
            end
        end
    endtask

    // Drive one cycle of requests and check the state entered at the falling edge
    task automatic cyc(input string tag, input logic ld, input logic br, input logic frz,
                       input logic [3:0] len, input logic [4:0] es, input logic [4:0] ef,
                       input logic en, input logic eb);
        exp_t e;
        e.tag = tag; e.stall = es; e.flush = ef; e.nop = en; e.busy = eb;
        sb.push_back(e);
        ld_use_req = ld; br_req = br; frz_req = frz; frz_len = len;
        @(negedge Clk);
        @(posedge Clk);
        #1;
        ld_use_req = 1'b0; br_req = 1'b0; frz_req = 1'b0; frz_len = 4'd0;
        check_out();
    endtask

    initial begin
        Rst = 1'b1; ld_use_req = 1'b0; br_req = 1'b0; frz_req = 1'b0; frz_len = 4'd0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst.stall", {27'd0, stall}, 32'd0);
        chk("rst.flush", {27'd0, flush}, 32'd0);
        chk("rst.nop",   {31'd0, nop},   32'd0);
        chk("rst.busy",  {31'd0, busy},  32'd0);
        chk("rst.cnt",   {28'd0, stall_cnt}, 32'd0);
        Rst = 1'b0;

        // Load-use bubble
        cyc("bub",     1'b1, 1'b0, 1'b0, 4'd0, S_BUB, Z, 1'b1, 1'b1);
        cyc("bub_end", 1'b0, 1'b0, 1'b0, 4'd0, Z,     Z, 1'b0, 1'b0);
        // Branch flush
        cyc("br",      1'b0, 1'b1, 1'b0, 4'd0, Z, F_BR, 1'b0, 1'b1);
        cyc("br_end",  1'b0, 1'b0, 1'b0, 4'd0, Z, Z,    1'b0, 1'b0);
        // Freeze 3 cycles; ignored early frz/ld, branch on 2nd cycle
        cyc("frz1",    1'b0, 1'b0, 1'b1, 4'd3, S_ALL, Z, 1'b0, 1'b1);
        cyc("frz2",    1'b1, 1'b0, 1'b1, 4'd5, S_ALL, Z, 1'b0, 1'b1);
        cyc("frz3",    1'b0, 1'b1, 1'b0, 4'd0, S_ALL, Z, 1'b0, 1'b1);
        cyc("frz_fl",  1'b0, 1'b0, 1'b0, 4'd0, Z, F_BR,  1'b0, 1'b1);
        cyc("frz_end", 1'b0, 1'b0, 1'b0, 4'd0, Z, Z,     1'b0, 1'b0);
        // All three requests with zero length: freeze 1, flush 1, no bubble
        cyc("all_frz", 1'b1, 1'b1, 1'b1, 4'd0, S_ALL, Z, 1'b0, 1'b1);
        cyc("all_fl",  1'b0, 1'b0, 1'b0, 4'd0, Z, F_BR,  1'b0, 1'b1);
        cyc("all_end", 1'b0, 1'b0, 1'b0, 4'd0, Z, Z,     1'b0, 1'b0);
        // Freeze extended by a request on the final cycle
        cyc("ext1",    1'b0, 1'b0, 1'b1, 4'd2, S_ALL, Z, 1'b0, 1'b1);
        cyc("ext2",    1'b0, 1'b0, 1'b0, 4'd0, S_ALL, Z, 1'b0, 1'b1);
        cyc("ext3",    1'b0, 1'b0, 1'b1, 4'd1, S_ALL, Z, 1'b0, 1'b1);
        cyc("ext_end", 1'b0, 1'b0, 1'b0, 4'd0, Z, Z,     1'b0, 1'b0);
        // Load-use during a bubble is dropped; branch during a bubble is taken
        cyc("bb1",     1'b1, 1'b0, 1'b0, 4'd0, S_BUB, Z, 1'b1, 1'b1);
        cyc("bb_ld",   1'b1, 1'b0, 1'b0, 4'd0, Z, Z,     1'b0, 1'b0);
        cyc("bb2",     1'b1, 1'b0, 1'b0, 4'd0, S_BUB, Z, 1'b1, 1'b1);
        cyc("bb_br",   1'b0, 1'b1, 1'b0, 4'd0, Z, F_BR,  1'b0, 1'b1);
        cyc("bb_end",  1'b0, 1'b0, 1'b0, 4'd0, Z, Z,     1'b0, 1'b0);
        // Long freeze drives the 4-bit stall counter into saturation
        cyc("sat0",    1'b0, 1'b0, 1'b1, 4'd8, S_ALL, Z, 1'b0, 1'b1);
        for (int i = 1; i < 8; i++) begin
            cyc($sformatf("sat%0d", i), 1'b0, 1'b0, 1'b0, 4'd0, S_ALL, Z, 1'b0, 1'b1);
        end
        cyc("sat_end", 1'b0, 1'b0, 1'b0, 4'd0, Z, Z, 1'b0, 1'b0);
        chk("sat.cnt", {28'd0, stall_cnt}, 32'd15);
        // Reset in the middle of a long freeze with a flush pending
        cyc("rf1",     1'b0, 1'b0, 1'b1, 4'd10, S_ALL, Z, 1'b0, 1'b1);
        cyc("rf2",     1'b0, 1'b1, 1'b0, 4'd0,  S_ALL, Z, 1'b0, 1'b1);
        cyc("rf3",     1'b0, 1'b0, 1'b0, 4'd0,  S_ALL, Z, 1'b0, 1'b1);
        Rst = 1'b1;
        #1;
        chk("arst.stall", {27'd0, stall}, 32'd0);
        chk("arst.flush", {27'd0, flush}, 32'd0);
        chk("arst.busy",  {31'd0, busy},  32'd0);
        chk("arst.cnt",   {28'd0, stall_cnt}, 32'd0);
        exp_cnt = 0;
        #1;
        Rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc($sformatf("post%0d", i), 1'b0, 1'b0, 1'b0, 4'd0, Z, Z, 1'b0, 1'b0);
        end
        cyc("post_bub", 1'b1, 1'b0, 1'b0, 4'd0, S_BUB, Z, 1'b1, 1'b1);
        cyc("post_end", 1'b0, 1'b0, 1'b0, 4'd0, Z, Z,     1'b0, 1'b0);

        chk("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
